// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for call/return with registered pop output
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous active-low reset
//   push       - store push_data on top (call)
//   push_data  - return address to store
//   pop        - remove top entry into ret_addr (return)
//   clr_err    - synchronous clear of the sticky error flags
//   ret_addr   - registered value of the last popped entry
//   STACK_POP  - one-cycle pulse: ret_addr valid, PC must load it
//   count      - number of valid entries (0..DEPTH)
//   empty/full - decodes of count
//   overflow/underflow - sticky error flags
module call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         ret_addr,
    output logic                     STACK_POP,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] top, wi;
    logic pop_ok, wr, inc, dec, ovf_ev, udf_ev;
    always_comb begin
        empty  = count == '0;
        full   = count == (AW+1)'(DEPTH);
        top    = AW'(count - 1'b1);
        pop_ok = pop && !empty;
        // push+pop on a non-empty stack replaces the top, so it is legal even when full
        wr     = push && (pop || !full);
        wi     = pop_ok ? top : count[AW-1:0];
        inc    = push && !full && (!pop || empty);
        dec    = pop_ok && !push;
        ovf_ev = push && !pop && full;
        udf_ev = pop && empty;
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wi] <= push_data;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            ret_addr  <= '0;
            STACK_POP <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count + (AW+1)'(inc) - (AW+1)'(dec);
            STACK_POP <= pop_ok;
            if (pop_ok) ret_addr <= mem[top];
            overflow  <= ovf_ev | (overflow & ~clr_err);
            underflow <= udf_ev | (underflow & ~clr_err);
        end
    end
endmodule
